// File: rtl/dbg_hart_ctl.sv
// Per-hart debug-mode controller: run/halt/resume sequencing,
// prioritised halt causes, address-match triggers and resumeack.
module dbg_hart_ctl #(
  parameter int XLEN = 32,
  parameter int NTRIG = 2,
  parameter bit RESET_HALT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt_req,
  input  logic                     resume_req,
  input  logic                     resethaltreq,
  input  logic                     dcsr_step,
  input  logic                     dcsr_ebreakm,
  input  logic                     instr_end,
  input  logic                     ebreak,
  input  logic                     interrupt,
  input  logic [XLEN-1:0]          pc_reg,
  input  logic [XLEN-1:0]          pc_next,
  input  logic                     mem_valid,
  input  logic                     mem_we,
  input  logic [XLEN-1:0]          mem_addr,
  input  logic                     core_quiesced,
  input  logic                     core_resumed,
  input  logic                     trig_we,
  input  logic [$clog2(NTRIG):0]   trig_idx,
  input  logic [2:0]               trig_cfg,
  input  logic [XLEN-1:0]          trig_addr,
  output logic                     debug_mode,
  output logic                     halt_core,
  output logic                     halted,
  output logic                     resume_core,
  output logic                     resume_ack,
  output logic [XLEN-1:0]          dpc,
  output logic                     dpc_we,
  output logic [2:0]               cause,
  output logic                     cause_we,
  output logic [NTRIG-1:0]         trig_hit
);

  typedef enum logic [1:0] {
    RUN,
    HALTING,
    HALTED,
    RESUMING
  } state_t;

  localparam logic [2:0] C_EBRK = 3'd1;
  localparam logic [2:0] C_TRIG = 3'd2;
  localparam logic [2:0] C_HREQ = 3'd3;
  localparam logic [2:0] C_STEP = 3'd4;
  localparam logic [2:0] C_RST  = 3'd5;

  state_t          state;
  logic [2:0]      cfg   [NTRIG];
  logic [XLEN-1:0] taddr [NTRIG];
  logic [NTRIG-1:0] match;
  logic            first_q;
  logic            rh_q;
  logic            step_q;
  logic            ack_q;
  logic            in_run;
  logic            ebk;
  logic            stp;
  logic            halt_now;
  logic [2:0]      cause_c;
  logic [XLEN-1:0] dpc_c;

  assign in_run = rst_n && (state == RUN);

  // cfg bits are {exec, store, load}
  always_comb begin
    match = '0;
    for (int i = 0; i < NTRIG; i++) begin
      match[i] = in_run && (
        (cfg[i][2] && instr_end &&
         pc_reg == taddr[i]) ||
        (cfg[i][1] && mem_valid && mem_we &&
         mem_addr == taddr[i]) ||
        (cfg[i][0] && mem_valid && !mem_we &&
         mem_addr == taddr[i]));
    end
  end

  assign ebk = ebreak && dcsr_ebreakm &&
               instr_end && !interrupt;
  assign stp = step_q && (instr_end || interrupt);

  always_comb begin
    halt_now = in_run;
    cause_c  = '0;
    dpc_c    = '0;
    if (|match) begin
      cause_c = C_TRIG;
      dpc_c   = pc_reg;
    end else if (ebk) begin
      cause_c = C_EBRK;
      dpc_c   = pc_reg;
    end else if (rh_q) begin
      cause_c = C_RST;
      dpc_c   = pc_reg;
    end else if (halt_req) begin
      cause_c = C_HREQ;
      dpc_c   = instr_end ? pc_next : pc_reg;
    end else if (stp) begin
      cause_c = C_STEP;
      dpc_c   = pc_next;
    end else begin
      halt_now = 1'b0;
    end
    if (!in_run) halt_now = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      first_q  <= 1'b1;
      rh_q     <= 1'b0;
      step_q   <= 1'b0;
      ack_q    <= 1'b0;
      trig_hit <= '0;
      for (int i = 0; i < NTRIG; i++) begin
        cfg[i]   <= '0;
        taddr[i] <= '0;
      end
    end else begin
      first_q <= 1'b0;
      ack_q   <= 1'b0;
      if (halt_now) begin
        rh_q   <= 1'b0;
        step_q <= 1'b0;
      end
      if (first_q) rh_q <= RESET_HALT_EN && resethaltreq;
      unique case (state)
        RUN:
          if (halt_now) state <= HALTING;
        HALTING:
          if (core_quiesced) state <= HALTED;
        HALTED:
          if (resume_req) state <= RESUMING;
        RESUMING:
          if (core_resumed) begin
            state  <= RUN;
            ack_q  <= 1'b1;
            step_q <= dcsr_step;
          end
        default:
          state <= RUN;
      endcase
      // a config write to an entry also clears its sticky hit
      for (int i = 0; i < NTRIG; i++) begin
        if (halt_now && match[i]) trig_hit[i] <= 1'b1;
        if (trig_we && int'(trig_idx) == i) begin
          cfg[i]      <= trig_cfg;
          taddr[i]    <= trig_addr;
          trig_hit[i] <= 1'b0;
        end
      end
    end
  end

  assign debug_mode  = (state != RUN) || halt_now;
  assign halt_core   = (state == HALTING) ||
                       (state == HALTED) || halt_now;
  assign halted      = (state == HALTED);
  assign resume_core = (state == RESUMING);
  assign resume_ack  = ack_q;
  assign dpc_we      = halt_now;
  assign cause_we    = halt_now;
  assign dpc         = halt_now ? dpc_c : '0;
  assign cause       = halt_now ? cause_c : '0;

endmodule

// File: tb/tb_dbg_hart_ctl.sv
// Bench for dbg_hart_ctl: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_dbg_hart_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_req, resume_req, resethaltreq;
  logic        dcsr_step, dcsr_ebreakm;
  logic        instr_end, ebreak, interrupt;
  logic [31:0] pc_reg, pc_next, mem_addr, trig_addr;
  logic        mem_valid, mem_we;
  logic        core_quiesced, core_resumed;
  logic        trig_we;
  logic [1:0]  trig_idx;
  logic [2:0]  trig_cfg;

  logic        debug_mode, halt_core, halted;
  logic        resume_core, resume_ack;
  logic [31:0] dpc;
  logic        dpc_we, cause_we;
  logic [2:0]  cause;
  logic [1:0]  trig_hit;

  logic        u1_dm, u1_hc, u1_hd, u1_rc, u1_ra;
  logic [31:0] u1_dpc;
  logic        u1_dwe, u1_cwe;
  logic [2:0]  u1_cause;
  logic [1:0]  u1_hit;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dbg_hart_ctl #(.XLEN(32), .NTRIG(2), .RESET_HALT_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .resume_req(resume_req), .resethaltreq(resethaltreq),
    .dcsr_step(dcsr_step), .dcsr_ebreakm(dcsr_ebreakm),
    .instr_end(instr_end), .ebreak(ebreak),
    .interrupt(interrupt), .pc_reg(pc_reg), .pc_next(pc_next),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .core_quiesced(core_quiesced), .core_resumed(core_resumed),
    .trig_we(trig_we), .trig_idx(trig_idx), .trig_cfg(trig_cfg),
    .trig_addr(trig_addr), .debug_mode(debug_mode),
    .halt_core(halt_core), .halted(halted),
    .resume_core(resume_core), .resume_ack(resume_ack),
    .dpc(dpc), .dpc_we(dpc_we), .cause(cause),
    .cause_we(cause_we), .trig_hit(trig_hit)
  );

  dbg_hart_ctl #(.XLEN(32), .NTRIG(2), .RESET_HALT_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .resume_req(resume_req), .resethaltreq(resethaltreq),
    .dcsr_step(dcsr_step), .dcsr_ebreakm(dcsr_ebreakm),
    .instr_end(instr_end), .ebreak(ebreak),
    .interrupt(interrupt), .pc_reg(pc_reg), .pc_next(pc_next),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .core_quiesced(core_quiesced), .core_resumed(core_resumed),
    .trig_we(trig_we), .trig_idx(trig_idx), .trig_cfg(trig_cfg),
    .trig_addr(trig_addr), .debug_mode(u1_dm),
    .halt_core(u1_hc), .halted(u1_hd),
    .resume_core(u1_rc), .resume_ack(u1_ra),
    .dpc(u1_dpc), .dpc_we(u1_dwe), .cause(u1_cause),
    .cause_we(u1_cwe), .trig_hit(u1_hit)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // model: phase 0 run, 1 halting, 2 halted, 3 resuming
  int        ph = 0;
  bit        started = 0;
  bit        m_first, m_rh, m_step, m_ack;
  bit [2:0]  m_cfg [2];
  bit [31:0] m_addr [2];
  bit [1:0]  m_hit;

  function automatic void eval(output bit hn, output bit [2:0] cs,
                               output bit [31:0] pv,
                               output bit [1:0] mt);
    hn = 0; cs = 0; pv = 0; mt = 0;
    if (rst_n === 1'b1 && ph == 0) begin
      for (int i = 0; i < 2; i++) begin
        if (m_cfg[i][2] && instr_end && pc_reg == m_addr[i])
          mt[i] = 1;
        if (m_cfg[i][1] && mem_valid && mem_we &&
            mem_addr == m_addr[i]) mt[i] = 1;
        if (m_cfg[i][0] && mem_valid && !mem_we &&
            mem_addr == m_addr[i]) mt[i] = 1;
      end
      hn = 1;
      if (mt != 0) begin
        cs = 2; pv = pc_reg;
      end else if (ebreak && dcsr_ebreakm && instr_end &&
                   !interrupt) begin
        cs = 1; pv = pc_reg;
      end else if (m_rh) begin
        cs = 5; pv = pc_reg;
      end else if (halt_req) begin
        cs = 3; pv = instr_end ? pc_next : pc_reg;
      end else if (m_step && (instr_end || interrupt)) begin
        cs = 4; pv = pc_next;
      end else begin
        hn = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit hn;
    bit [2:0] cs;
    bit [31:0] pv;
    bit [1:0] mt, h;
    eval(hn, cs, pv, mt);
    started <= 1;
    if (rst_n !== 1'b1) begin
      ph <= 0; m_first <= 1; m_rh <= 0; m_step <= 0;
      m_ack <= 0; m_hit <= 0;
      for (int i = 0; i < 2; i++) begin
        m_cfg[i] <= 0; m_addr[i] <= 0;
      end
    end else begin
      m_ack <= 0;
      m_first <= 0;
      if (hn) begin
        ph <= 1; m_rh <= 0; m_step <= 0;
      end else if (ph == 1 && core_quiesced) ph <= 2;
      else if (ph == 2 && resume_req) ph <= 3;
      else if (ph == 3 && core_resumed) begin
        ph <= 0; m_ack <= 1; m_step <= dcsr_step;
      end
      if (m_first) m_rh <= resethaltreq;
      h = m_hit | (hn ? mt : 2'b00);
      if (trig_we && trig_idx < 2) begin
        m_cfg[trig_idx]  <= trig_cfg;
        m_addr[trig_idx] <= trig_addr;
        h[trig_idx] = 1'b0;
      end
      m_hit <= h;
    end
  end

  always @(negedge clk) begin
    bit hn;
    bit [2:0] cs;
    bit [31:0] pv;
    bit [1:0] mt;
    if (started) begin
      eval(hn, cs, pv, mt);
      chk("debug_mode", debug_mode, (ph != 0) || hn);
      chk("halt_core", halt_core, ph == 1 || ph == 2 || hn);
      chk("halted", halted, ph == 2);
      chk("resume_core", resume_core, ph == 3);
      chk("resume_ack", resume_ack, m_ack);
      chk("dpc_we", dpc_we, hn);
      chk("cause_we", cause_we, hn);
      chk("dpc", dpc, hn ? pv : 32'h0);
      chk("cause", cause, hn ? cs : 3'd0);
      chk("trig_hit", trig_hit, m_hit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    halt_req = 0; resume_req = 0; dcsr_step = 0;
    dcsr_ebreakm = 0; instr_end = 0; ebreak = 0;
    interrupt = 0; pc_reg = 0; pc_next = 0;
    mem_valid = 0; mem_we = 0; mem_addr = 0;
    core_quiesced = 0; core_resumed = 0; trig_we = 0;
    trig_idx = 0; trig_cfg = 0; trig_addr = 0;
  endtask

  task automatic resume_seq(input bit stp);
    idle();
    core_quiesced = 1;
    tick();
    core_quiesced = 0;
    resume_req = 1;
    tick();
    resume_req = 0;
    core_resumed = 1;
    dcsr_step = stp;
    tick();
    idle();
  endtask

  logic [31:0] atab [4] = '{32'h80, 32'h100, 32'h200, 32'h300};

  initial begin
    rst_n = 0; resethaltreq = 0;
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("rst dm", debug_mode, 0);
    chk("rst halted", halted, 0);
    chk("rst hit", trig_hit, 0);
    chk("rst dpc_we", dpc_we, 0);
    tick();
    rst_n = 1;
    tick();
    halt_req = 1; instr_end = 1;
    pc_reg = 32'h100; pc_next = 32'h104;
    @(negedge clk);
    chk("hreq dpc_we", dpc_we, 1);
    chk("hreq dpc", dpc, 32'h104);
    chk("hreq cause", cause, 3);
    tick();
    idle();
    @(negedge clk);
    chk("hreq once", dpc_we, 0);
    chk("hreq hold", halt_core, 1);
    tick();
    core_quiesced = 1;
    @(negedge clk);
    chk("pre halted", halted, 0);
    tick();
    core_quiesced = 0;
    @(negedge clk);
    chk("halted", halted, 1);

    resume_req = 1;
    tick();
    resume_req = 0;
    @(negedge clk);
    chk("res core", resume_core, 1);
    chk("res hc", halt_core, 0);
    tick();
    tick();
    core_resumed = 1;
    @(negedge clk);
    chk("pre ack", resume_ack, 0);
    tick();
    core_resumed = 0;
    @(negedge clk);
    chk("ack", resume_ack, 1);
    chk("ack dm", debug_mode, 0);
    chk("ack halted", halted, 0);
    tick();
    @(negedge clk);
    chk("ack pulse", resume_ack, 0);

    trig_we = 1; trig_idx = 1; trig_cfg = 3'b100;
    trig_addr = 32'h200;
    tick();
    idle();
    pc_reg = 32'h200; pc_next = 32'h204; instr_end = 1;
    @(negedge clk);
    chk("exec cause", cause, 2);
    chk("exec dpc", dpc, 32'h200);
    tick();
    idle();
    @(negedge clk);
    chk("exec hit", trig_hit, 2'b10);
    resume_seq(0);
    trig_we = 1; trig_idx = 1; trig_cfg = 0; trig_addr = 0;
    tick();
    idle();
    @(negedge clk);
    chk("hit clr", trig_hit, 0);

    trig_we = 1; trig_idx = 0; trig_cfg = 3'b010;
    trig_addr = 32'h80;
    tick();
    idle();
    ebreak = 1; dcsr_ebreakm = 1; instr_end = 1;
    pc_reg = 32'h300; pc_next = 32'h304;
    mem_valid = 1; mem_we = 1; mem_addr = 32'h80;
    @(negedge clk);
    chk("tvb cause", cause, 2);
    chk("tvb dpc", dpc, 32'h300);
    tick();
    idle();
    @(negedge clk);
    chk("tvb once", dpc_we, 0);
    chk("tvb hit", trig_hit, 2'b01);

    resume_seq(1);
    instr_end = 1; pc_reg = 32'h304; pc_next = 32'h308;
    trig_we = 1; trig_idx = 0; trig_cfg = 0; trig_addr = 0;
    @(negedge clk);
    chk("step cause", cause, 4);
    chk("step dpc", dpc, 32'h308);
    tick();
    idle();
    resume_seq(0);
    ebreak = 1; dcsr_ebreakm = 0; instr_end = 1;
    pc_reg = 32'h308; pc_next = 32'h30c;
    @(negedge clk);
    chk("ebk off dm", debug_mode, 0);
    chk("ebk off we", dpc_we, 0);
    tick();
    idle();

    rst_n = 0; resethaltreq = 1;
    tick();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("rh first", debug_mode, 0);
    tick();
    @(negedge clk);
    chk("rh cause", cause, 5);
    chk("rh we", cause_we, 1);
    chk("rh dpc", dpc, 0);
    chk("rh off", u1_dm, 0);
    tick();
    resethaltreq = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rh off run", u1_dm, 0);
      tick();
    end
    resume_seq(0);

    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      resethaltreq = $urandom_range(0, 1);
      halt_req = ($urandom_range(0, 11) == 0);
      resume_req = ($urandom_range(0, 3) == 0);
      dcsr_step = ($urandom_range(0, 2) == 0);
      dcsr_ebreakm = $urandom_range(0, 1);
      instr_end = $urandom_range(0, 1);
      ebreak = ($urandom_range(0, 5) == 0);
      interrupt = ($urandom_range(0, 7) == 0);
      pc_reg = atab[$urandom_range(0, 3)];
      pc_next = pc_reg + 32'h4;
      mem_valid = $urandom_range(0, 1);
      mem_we = $urandom_range(0, 1);
      mem_addr = atab[$urandom_range(0, 3)];
      core_quiesced = ($urandom_range(0, 2) == 0);
      core_resumed = ($urandom_range(0, 2) == 0);
      trig_we = ($urandom_range(0, 9) == 0);
      trig_idx = 2'($urandom_range(0, 3));
      trig_cfg = 3'($urandom_range(0, 7));
      trig_addr = atab[$urandom_range(0, 3)];
      tick();
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_hart_ctl.md
Name: dbg_hart_ctl

Overview:
- Parametrised per-hart debug-mode controller; next generation of the core's debug control logic.
- Sits between the Debug Module hart interface and the core microsequencer.
- Sequences run/halt/resume with an explicit state machine and prioritises halt causes, including a new NTRIG-entry address-match trigger unit and halt-on-reset.
- Produces DPC/DCSR.cause update strobes and a resume acknowledge.

Parameters:
XLEN, 32, data/address width
NTRIG, 2, number of address-match triggers (1..8)
RESET_HALT_EN, 1, honour resethaltreq after reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
halt_req  in  1  DM haltreq level
resume_req  in  1  DM resumereq pulse
resethaltreq  in  1  DM resethaltreq level, sampled at reset release
dcsr_step  in  1  DCSR.step
dcsr_ebreakm  in  1  DCSR.ebreakm
instr_end  in  1  current instruction commits this cycle
ebreak  in  1  committing instruction is EBREAK
interrupt  in  1  interrupt taken this cycle
pc_reg  in  XLEN  PC of current instruction
pc_next  in  XLEN  PC of next instruction
mem_valid  in  1  load/store address valid
mem_we  in  1  store when 1
mem_addr  in  XLEN  load/store address
core_quiesced  in  1  microsequencer reached halted state
core_resumed  in  1  microsequencer left resuming state
trig_we  in  1  trigger config write
trig_idx  in  $clog2(NTRIG)+1  trigger index
trig_cfg  in  3  {exec, store, load} match enables
trig_addr  in  XLEN  match address (tdata2)
debug_mode  out  1  hart in debug mode
halt_core  out  1  request core to enter halted microstate
halted  out  1  hart halted (to DM)
resume_core  out  1  request core to resume
resume_ack  out  1  one-cycle resumeack pulse
dpc  out  XLEN  DPC value to write
dpc_we  out  1  DPC write strobe
cause  out  3  DCSR.cause value
cause_we  out  1  DCSR.cause write strobe
trig_hit  out  NTRIG  sticky per-trigger hit flags

Behaviour:
- Reset: all outputs 0; state RUN; all triggers disabled; trig_hit 0.
- States: RUN, HALTING, HALTED, RESUMING.
- Trigger match, combinational. Entry i hits if:
  - exec enabled and pc_reg==addr_i and instr_end; or
  - load enabled and mem_valid && !mem_we && mem_addr==addr_i; or
  - store enabled and mem_valid && mem_we && mem_addr==addr_i.
- Trigger config: trig_we writes entry trig_idx next cycle. trig_idx>=NTRIG is ignored. Writes are accepted in any state, but matches are evaluated only in RUN.
- Halt causes, evaluated in RUN only, in priority order:
  - trigger (cause 2, dpc=pc_reg)
  - ebreak && dcsr_ebreakm && instr_end && !interrupt (cause 1, dpc=pc_reg)
  - reset-halt (cause 5, dpc=pc_reg)
  - halt_req (cause 3, dpc=instr_end?pc_next:pc_reg)
  - step armed && (instr_end||interrupt) (cause 4, dpc=pc_next)
- Reset-halt is a one-shot flag, set at the first cycle after reset release if RESET_HALT_EN && resethaltreq. It is cleared when consumed.
- Step arm: set on RUN entry from RESUMING when dcsr_step=1. Cleared on any halt. The instruction that resumes execution is stepped exactly once.
- RUN→HALTING on any cause, same cycle:
  - dpc_we=1 and cause_we=1 for exactly one cycle;
  - debug_mode=1 and halt_core=1 combinationally that cycle, then held;
  - trig_hit[i] set for every matching entry.
- HALTING→HALTED when core_quiesced. halted=1 from the next cycle.
- HALTED: halt_core held. halt_req is ignored. resume_req→RESUMING, with halt_core=0 and resume_core=1.
- RESUMING→RUN on core_resumed:
  - resume_ack pulses 1 cycle;
  - debug_mode=0, halted=0, resume_core=0.
- resume_req outside HALTED is ignored.
- halt_req still high on RUN re-entry halts again on the next cycle (cause 3).
- Simultaneous events: the cause is the highest-priority active cause. Only one dpc/cause write occurs per halt entry.
- trig_hit is cleared by trig_we to the same index.
- rst_n low in any state → RUN with all outputs 0 next edge. Reset takes priority over all events.

Test Plan:
- Halt request: after reset, pulse halt_req for 1 cycle with instr_end=1, pc_next=0x104 → dpc=0x104 and cause=3 strobed once; core_quiesced 2 cycles later → halted=1.
- Resume: in HALTED, resume_req, then core_resumed after 3 cycles → resume_ack is a single pulse; debug_mode=0 and halted=0 that cycle.
- Exec trigger: trigger 1 exec at 0x200; pc_reg=0x200, instr_end=1 → cause=2, dpc=0x200, trig_hit=2'b10.
- Trigger vs EBREAK: simultaneous ebreak with ebreakm=1 and store trigger 0 hit at mem_addr 0x80 → cause=2 (trigger wins); single dpc_we.
- Single step: resume with dcsr_step=1 → first instr_end with pc_next=0x308 gives cause=4, dpc=0x308; EBREAK with ebreakm=0 gives no halt.
- Halt on reset: resethaltreq=1 at reset release with pc_reg=0x0 → cause=5 one cycle after reset; RESET_HALT_EN=0 → stays RUN.
